// File: rtl/cam_sccb_slave.sv
// cam_sccb_slave: SCCB responder that oversamples sioc/siod on clk and maps
// 3-phase writes, 2-phase writes and 2-phase reads onto a register port.
`default_nettype none

module cam_sccb_slave #(
  parameter logic [7:0] DEV_ID = 8'h42,
  parameter bit         ACK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sioc,
  input  logic       siod_in,
  output logic       siod_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_ID     = 4'd1;
  localparam logic [3:0] S_ID_X   = 4'd2;
  localparam logic [3:0] S_SUB    = 4'd3;
  localparam logic [3:0] S_SUB_X  = 4'd4;
  localparam logic [3:0] S_DATA   = 4'd5;
  localparam logic [3:0] S_DATA_X = 4'd6;
  localparam logic [3:0] S_RD     = 4'd7;
  localparam logic [3:0] S_RD_X   = 4'd8;
  localparam logic [3:0] S_IGNORE = 4'd9;

  // [0],[1] synchronize, [2] is the previous synchronized level for edge detect
  logic [2:0] sioc_sr;
  logic [2:0] siod_sr;
  logic       sioc_rise;
  logic       sioc_fall;
  logic       start_ev;
  logic       stop_ev;
  logic       sda_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sioc_sr   <= 3'b111;
      siod_sr   <= 3'b111;
      sioc_rise <= 1'b0;
      sioc_fall <= 1'b0;
      start_ev  <= 1'b0;
      stop_ev   <= 1'b0;
      sda_bit   <= 1'b1;
    end else begin
      sioc_sr   <= {sioc_sr[1:0], sioc};
      siod_sr   <= {siod_sr[1:0], siod_in};
      sioc_rise <= sioc_sr[1] & ~sioc_sr[2];
      sioc_fall <= ~sioc_sr[1] & sioc_sr[2];
      start_ev  <= sioc_sr[1] & siod_sr[2] & ~siod_sr[1];
      stop_ev   <= sioc_sr[1] & ~siod_sr[2] & siod_sr[1];
      sda_bit   <= siod_sr[1];
    end
  end

  logic [3:0] state;
  logic [3:0] bit_cnt;
  logic [6:0] shreg;
  logic       x_drv;
  logic       rw;
  logic [7:0] rx_byte;
  logic       last_bit;

  assign rx_byte  = {shreg, sda_bit};
  assign last_bit = sioc_rise && (bit_cnt == 4'd7);
  assign busy     = (state != S_IDLE) && (state != S_IGNORE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      bit_cnt   <= 4'd0;
      shreg     <= 7'd0;
      x_drv     <= 1'b0;
      rw        <= 1'b0;
      siod_oe   <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      reg_wr_en <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      if (stop_ev) begin
        state   <= S_IDLE;
        bit_cnt <= 4'd0;
        siod_oe <= 1'b0;
      end else if (start_ev) begin
        state   <= S_ID;
        bit_cnt <= 4'd0;
        x_drv   <= 1'b0;
        siod_oe <= 1'b0;
      end else begin
        case (state)
          S_ID, S_SUB, S_DATA: begin
            if (sioc_rise) begin
              shreg   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 4'd1;
            end
            if (last_bit) begin
              x_drv <= 1'b0;
              if (state == S_ID) begin
                if (rx_byte[7:1] != DEV_ID[7:1]) begin
                  state <= S_IGNORE;
                end else begin
                  rw    <= rx_byte[0];
                  state <= S_ID_X;
                end
              end else if (state == S_SUB) begin
                reg_addr <= rx_byte;
                state    <= S_SUB_X;
              end else begin
                reg_wdata <= rx_byte;
                reg_wr_en <= 1'b1;
                state     <= S_DATA_X;
              end
            end
          end

          // First fall opens the 9th phase, second fall closes it
          S_ID_X, S_SUB_X, S_DATA_X, S_RD_X: begin
            if (sioc_fall) begin
              if (!x_drv) begin
                x_drv   <= 1'b1;
                siod_oe <= ACK_EN && (state != S_RD_X);
              end else begin
                x_drv   <= 1'b0;
                bit_cnt <= 4'd0;
                siod_oe <= 1'b0;
                case (state)
                  S_ID_X: begin
                    if (rw) begin
                      state   <= S_RD;
                      shreg   <= reg_rdata[6:0];
                      siod_oe <= ~reg_rdata[7];
                    end else begin
                      state <= S_SUB;
                    end
                  end
                  S_SUB_X: state <= S_DATA;
                  default: state <= S_IGNORE;
                endcase
              end
            end
          end

          S_RD: begin
            if (sioc_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                state <= S_RD_X;
                x_drv <= 1'b0;
              end
            end else if (sioc_fall) begin
              siod_oe <= ~shreg[6];
              shreg   <= {shreg[5:0], 1'b0};
            end
          end

          default: begin
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cam_sccb_slave.sv
// tb_cam_sccb_slave: bit-banged SCCB master plus register-file model checking
// cam_sccb_slave against a transaction-level reference.
`default_nettype none
`timescale 1ns/1ps

module tb_cam_sccb_slave;

  localparam int Q = 10;  // quarter sioc period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sioc = 1'b1;
  logic       sda = 1'b1;
  logic       siod_in;
  logic       siod_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en;
  logic [7:0] reg_rdata;
  logic       busy;

  cam_sccb_slave dut (
    .clk      (clk),
    .reset    (reset),
    .sioc     (sioc),
    .siod_in  (siod_in),
    .siod_oe  (siod_oe),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_wr_en(reg_wr_en),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  always #10 clk = ~clk;

  assign siod_in = sda & ~siod_oe;

  // bench-side register file served to the DUT
  logic [7:0] regfile [256];
  logic       mem_init = 1'b1;
  assign reg_rdata = regfile[reg_addr];

  function automatic logic [7:0] seed(input int i);
    return (i == 10) ? 8'h76 : 8'((i * 29 + 3) & 255);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) regfile[i] <= seed(i);
    end else if (reg_wr_en) begin
      regfile[reg_addr] <= reg_wdata;
    end
  end

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  logic oe_seen = 1'b0;
  logic prev_wr = 1'b0;
  logic [15:0] strobes [$];
  logic [15:0] exp_strobes [$];
  logic [7:0]  exp_mem [256];
  logic [7:0]  exp_addr = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (siod_oe) oe_seen = 1'b1;
    if (reg_wr_en) begin
      strobes.push_back({reg_addr, reg_wdata});
      check("wr_single_pulse", {31'd0, prev_wr}, 0);
      if (!prev_wr) check("wr_latency", cyc - last_rise_cyc, 4);
    end
    prev_wr = reg_wr_en;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda = 1'b1; tick(Q);
    sioc = 1'b1; tick(Q);
    sda = 1'b0; tick(Q);
    sioc = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda = 1'b0; tick(Q);
    sioc = 1'b1; tick(Q);
    sda = 1'b1; tick(2 * Q);
  endtask

  task automatic bus_bit(input logic v, output logic line);
    sda = v; tick(Q);
    sioc = 1'b1; last_rise_cyc = cyc; tick(Q);
    line = siod_in; tick(Q);
    sioc = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic l;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], l);
    bus_bit(1'b1, ack);
  endtask

  task automatic recv_byte(output logic [7:0] b, output logic na);
    logic l;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, l);
      b[i] = l;
    end
    bus_bit(1'b1, na);
  endtask

  task automatic check_strobes();
    check("strobe_count", strobes.size(), exp_strobes.size());
    while (strobes.size() > 0 && exp_strobes.size() > 0)
      check("strobe_addr_data", strobes.pop_front(), exp_strobes.pop_front());
    strobes.delete();
    exp_strobes.delete();
    check("reg_addr", reg_addr, exp_addr);
  endtask

  task automatic wr3(input logic [7:0] sub, input logic [7:0] dat);
    logic a;
    bus_start();
    send_byte(8'h42, a); check("wr3_ack_id", a, 0);
    check("wr3_busy", busy, 1);
    send_byte(sub, a);   check("wr3_ack_sub", a, 0);
    send_byte(dat, a);   check("wr3_ack_data", a, 0);
    bus_stop();
    exp_addr = sub;
    exp_mem[sub] = dat;
    exp_strobes.push_back({sub, dat});
    check_strobes();
  endtask

  task automatic wr2(input logic [7:0] sub);
    logic a;
    bus_start();
    send_byte(8'h42, a); check("wr2_ack_id", a, 0);
    send_byte(sub, a);   check("wr2_ack_sub", a, 0);
    bus_stop();
    exp_addr = sub;
    check_strobes();
  endtask

  task automatic rd();
    logic a;
    logic [7:0] b;
    logic na;
    bus_start();
    send_byte(8'h43, a); check("rd_ack_id", a, 0);
    recv_byte(b, na);
    check("rd_data", b, exp_mem[exp_addr]);
    check("rd_line_released", na, 1);
    bus_stop();
    check_strobes();
  endtask

  task automatic wrong_id(input logic [7:0] id, input logic [7:0] b1, input logic [7:0] b2);
    logic a;
    oe_seen = 1'b0;
    bus_start();
    send_byte(id, a); check("bad_id_no_ack", a, 1);
    check("bad_id_busy", busy, 0);
    send_byte(b1, a);
    send_byte(b2, a);
    bus_stop();
    check("bad_id_oe_never", oe_seen, 0);
    check_strobes();
  endtask

  initial begin
    logic a;
    logic l;
    logic [7:0] b;
    logic na;
    for (int i = 0; i < 256; i++) exp_mem[i] = seed(i);
    tick(5);
    check("rst_siod_oe", siod_oe, 0);
    check("rst_wr_en", reg_wr_en, 0);
    check("rst_addr", reg_addr, 8'h00);
    check("rst_wdata", reg_wdata, 8'h00);
    check("rst_busy", busy, 0);
    mem_init = 1'b0;
    reset = 1'b1;
    tick(5);

    wr3(8'h12, 8'h80);
    check("wr3_wdata", reg_wdata, 8'h80);
    wr2(8'h0A);
    rd();
    wrong_id(8'h60, 8'h12, 8'h34);

    // abort a subaddress after 5 bits
    bus_start();
    send_byte(8'h42, a); check("part_ack_id", a, 0);
    for (int i = 0; i < 5; i++) bus_bit(1'b1, l);
    bus_stop();
    check("part_busy", busy, 0);
    check_strobes();

    // repeated start after the subaddress, then read from it
    bus_start();
    send_byte(8'h42, a); check("rs_ack_id", a, 0);
    send_byte(8'h12, a); check("rs_ack_sub", a, 0);
    sda = 1'b1; tick(Q);
    sioc = 1'b1; tick(Q);
    sda = 1'b0; tick(Q);
    sioc = 1'b0; tick(Q);
    exp_addr = 8'h12;
    send_byte(8'h43, a); check("rs_ack_rd", a, 0);
    recv_byte(b, na);
    check("rs_rd_data", b, exp_mem[8'h12]);
    bus_stop();
    check_strobes();

    // reset in the middle of a read while the slave is pulling low
    wr2(8'h0A);
    bus_start();
    send_byte(8'h43, a); check("abort_ack_id", a, 0);
    sda = 1'b1; tick(Q);
    sioc = 1'b1; tick(Q);
    check("abort_oe_before", siod_oe, {31'd0, ~exp_mem[8'h0A][7]});
    reset = 1'b0;
    #1;
    check("abort_oe_async", siod_oe, 0);
    check("abort_busy", busy, 0);
    check("abort_addr", reg_addr, 8'h00);
    exp_addr = 8'h00;
    tick(3);
    reset = 1'b1;
    tick(5);
    wr3(8'h33, 8'h5C);

    for (int n = 0; n < 16; n++) begin
      logic [7:0] s, d, id;
      s  = 8'($urandom);
      d  = 8'($urandom);
      id = 8'($urandom);
      case ($urandom_range(0, 3))
        0: wr3(s, d);
        1: wr2(s);
        2: rd();
        default: begin
          if (id[7:1] == 7'h21) id[7] = ~id[7];
          wrong_id(id, s, d);
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
